// File: rtl/key_event_pkg.sv
// Shared state encoding and default 50 MHz timing constants for the key event decoder.
package key_event_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PRESS1 = 3'd1,
    S_WAIT2  = 3'd2,
    S_PRESS2 = 3'd3,
    S_LONG   = 3'd4
  } key_state_e;

  localparam int unsigned DEF_LONG_CNT = 32'd50_000_000;
  localparam int unsigned DEF_DBL_CNT  = 32'd15_000_000;
  localparam int unsigned DEF_REP_CNT  = 32'd10_000_000;
  localparam int unsigned DEF_CNT_W    = 32'd26;

endpackage

// File: rtl/key_event_decoder.sv
// Classifies a debounced key level into press, click, double-click, long-press and
// auto-repeat pulses; every output is registered, one cycle after the causing edge.
module key_event_decoder
  import key_event_pkg::*;
#(
  parameter int unsigned LONG_CNT = DEF_LONG_CNT,
  parameter int unsigned DBL_CNT  = DEF_DBL_CNT,
  parameter int unsigned REP_CNT  = DEF_REP_CNT,
  parameter int unsigned CNT_W    = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_filter,
  output logic key_press,
  output logic key_click,
  output logic key_double,
  output logic key_long,
  output logic key_repeat,
  output logic key_hold
);

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CNT - 32'd1);
  localparam logic [CNT_W-1:0] DBL_LAST  = CNT_W'(DBL_CNT - 32'd1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REP_CNT - 32'd1);
  localparam logic [CNT_W-1:0] TIMER_MAX = {CNT_W{1'b1}};

  key_state_e       state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic             key_q;
  logic             rise_s, fall_s, timer_clr_s;
  logic             press_d, click_d, double_d, long_d, repeat_d;

  assign rise_s = key_filter & ~key_q;
  assign fall_s = ~key_filter & key_q;

  // Next-state and pulse decode; edges take priority over timer expiry in every state.
  always_comb begin
    state_d     = state_q;
    timer_clr_s = 1'b0;
    press_d     = 1'b0;
    click_d     = 1'b0;
    double_d    = 1'b0;
    long_d      = 1'b0;
    repeat_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (rise_s) begin
          state_d = S_PRESS1;
          press_d = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_PRESS1: begin
        if (fall_s) begin
          state_d = S_WAIT2;
        end else if (timer_q == LONG_LAST) begin
          state_d = S_LONG;
          long_d  = 1'b1;
        end else begin
          state_d = S_PRESS1;
        end
      end
      S_WAIT2: begin
        if (rise_s) begin
          state_d = S_PRESS2;
          press_d = 1'b1;
        end else if (timer_q == DBL_LAST) begin
          state_d = S_IDLE;
          click_d = 1'b1;
        end else begin
          state_d = S_WAIT2;
        end
      end
      S_PRESS2: begin
        if (fall_s) begin
          state_d  = S_IDLE;
          double_d = 1'b1;
        end else if (timer_q == LONG_LAST) begin
          state_d = S_LONG;
          long_d  = 1'b1;
        end else begin
          state_d = S_PRESS2;
        end
      end
      S_LONG: begin
        if (fall_s) begin
          state_d = S_IDLE;
        end else if (timer_q == REP_LAST) begin
          repeat_d    = 1'b1;
          timer_clr_s = 1'b1;
        end else begin
          state_d = S_LONG;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Timer restarts on any state change or repeat, and saturates rather than wrapping while idle.
  always_comb begin
    timer_d = timer_q;
    if ((state_d != state_q) || timer_clr_s) begin
      timer_d = '0;
    end else if (timer_q != TIMER_MAX) begin
      timer_d = timer_q + CNT_W'(1);
    end else begin
      timer_d = timer_q;
    end
  end

  // State, timer, edge-detect and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      timer_q    <= '0;
      key_q      <= 1'b0;
      key_press  <= 1'b0;
      key_click  <= 1'b0;
      key_double <= 1'b0;
      key_long   <= 1'b0;
      key_repeat <= 1'b0;
      key_hold   <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      key_q      <= key_filter;
      key_press  <= press_d;
      key_click  <= click_d;
      key_double <= double_d;
      key_long   <= long_d;
      key_repeat <= repeat_d;
      key_hold   <= key_filter;
    end
  end

endmodule

// File: tb/tb_key_event_decoder.sv
// Self-checking bench: timestamp-based reference model compared every cycle, plus directed pulse-count checks.
module tb_key_event_decoder;

  localparam int LONG_CNT = 20;
  localparam int DBL_CNT  = 10;
  localparam int REP_CNT  = 5;
  localparam int CNT_W    = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic key_filter = 1'b0;
  logic key_press, key_click, key_double, key_long, key_repeat, key_hold;

  int tests = 0;
  int fails = 0;
  int cnt [5] = '{0, 0, 0, 0, 0};
  int base [5];
  string pname [5] = '{"press", "click", "double", "long", "repeat"};

  key_event_decoder #(
    .LONG_CNT(LONG_CNT), .DBL_CNT(DBL_CNT), .REP_CNT(REP_CNT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .key_filter(key_filter),
    .key_press(key_press), .key_click(key_click), .key_double(key_double),
    .key_long(key_long), .key_repeat(key_repeat), .key_hold(key_hold)
  );

  always #5 clk = ~clk;

  // Phases: 0 idle, 1 first press, 2 waiting for second press, 3 second press, 4 long hold.
  // ts is the edge number at which the current phase began; e = {press,click,double,long,repeat,hold}.
  typedef struct {
    int         ph;
    int         ts;
    logic [5:0] e;
  } step_t;

  step_t m_r = '{0, 0, 6'b0};
  int    m_cyc = 0;
  logic  m_pk = 1'b0;

  function automatic step_t step(int ph, int ts, int cyc, logic k, logic pk);
    step_t s;
    int    el;
    logic  rise, fall;
    s.ph = ph;
    s.ts = ts;
    s.e  = 6'b0;
    rise = k & ~pk;
    fall = ~k & pk;
    el   = cyc - ts;
    case (ph)
      0: if (rise) begin s.ph = 1; s.ts = cyc; s.e[5] = 1'b1; end
      1: if (fall) begin s.ph = 2; s.ts = cyc; end
         else if (el == LONG_CNT) begin s.ph = 4; s.ts = cyc; s.e[2] = 1'b1; end
      2: if (rise) begin s.ph = 3; s.ts = cyc; s.e[5] = 1'b1; end
         else if (el == DBL_CNT) begin s.ph = 0; s.e[4] = 1'b1; end
      3: if (fall) begin s.ph = 0; s.e[3] = 1'b1; end
         else if (el == LONG_CNT) begin s.ph = 4; s.ts = cyc; s.e[2] = 1'b1; end
      4: if (fall) begin s.ph = 0; end
         else if (el % REP_CNT == 0) s.e[1] = 1'b1;
      default: s.ph = 0;
    endcase
    s.e[0] = k;
    return s;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_r   <= '{0, 0, 6'b0};
      m_cyc <= 0;
      m_pk  <= 1'b0;
    end else begin
      m_r   <= step(m_r.ph, m_r.ts, m_cyc, key_filter, m_pk);
      m_cyc <= m_cyc + 1;
      m_pk  <= key_filter;
    end
  end

  // Per-cycle compare against the model, mutual-exclusion check, and pulse tallies.
  always @(negedge clk) begin
    logic [5:0] got;
    got = {key_press, key_click, key_double, key_long, key_repeat, key_hold};
    tests++;
    if (got !== m_r.e) begin
      fails++;
      $display("FAIL cycle_compare t=%0t got=%b expected=%b", $time, got, m_r.e);
    end
    tests++;
    if ($countones(got[4:1]) > 1) begin
      fails++;
      $display("FAIL exclusive t=%0t got=%b expected at most one of click/double/long/repeat", $time, got);
    end
    cnt[0] = cnt[0] + int'(key_press);
    cnt[1] = cnt[1] + int'(key_click);
    cnt[2] = cnt[2] + int'(key_double);
    cnt[3] = cnt[3] + int'(key_long);
    cnt[4] = cnt[4] + int'(key_repeat);
  end

  task automatic chk(string nm, int got, int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s got=%0d expected=%0d", nm, got, exp);
    end
  endtask

  task automatic hold(logic v, int n);
    key_filter = v;
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic snap();
    for (int i = 0; i < 5; i++) base[i] = cnt[i];
  endtask

  task automatic deltas(string nm, int p, int c, int d, int l, int r);
    int exp [5];
    exp = '{p, c, d, l, r};
    for (int i = 0; i < 5; i++) chk({nm, "_", pname[i]}, cnt[i] - base[i], exp[i]);
  endtask

  initial begin
    int seg;
    logic lvl;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;

    snap();
    hold(1'b0, 50);
    deltas("idle", 0, 0, 0, 0, 0);

    snap();
    hold(1'b1, 1);
    @(negedge clk);
    #1;
    chk("press_latency", int'(key_press), 1);
    @(posedge clk);
    #2;
    hold(1'b1, 2);
    hold(1'b0, 11);
    chk("click_at_10", int'(key_click), 1);
    hold(1'b0, 10);
    deltas("single", 1, 1, 0, 0, 0);

    snap();
    hold(1'b1, 4);
    hold(1'b0, 3);
    hold(1'b1, 4);
    hold(1'b0, 1);
    chk("double_latency", int'(key_double), 1);
    hold(1'b0, 15);
    deltas("double", 2, 0, 1, 0, 0);

    snap();
    hold(1'b1, 40);
    hold(1'b0, 15);
    deltas("long", 1, 0, 0, 1, 3);

    for (int g = 9; g <= 11; g++) begin
      snap();
      hold(1'b1, 4);
      hold(1'b0, g);
      hold(1'b1, 4);
      hold(1'b0, 25);
      if (g <= 10) deltas($sformatf("gap%0d", g), 2, 0, 1, 0, 0);
      else         deltas($sformatf("gap%0d", g), 2, 2, 0, 0, 0);
    end

    hold(1'b1, 4);
    hold(1'b0, 3);
    rst_n = 1'b0;
    hold(1'b1, 3);
    snap();
    rst_n = 1'b1;
    hold(1'b1, 1);
    @(negedge clk);
    #1;
    chk("reset_rise_press", int'(key_press), 1);
    @(posedge clk);
    #2;
    hold(1'b1, 23);
    hold(1'b0, 15);
    deltas("reset_wait2", 1, 0, 0, 1, 0);

    lvl = 1'b0;
    for (int i = 0; i < 250; i++) begin
      lvl = ~lvl;
      seg = int'($urandom_range(1, 30));
      if ($urandom_range(0, 39) == 0) begin
        rst_n = 1'b0;
        hold(lvl, 2);
        rst_n = 1'b1;
      end
      hold(lvl, seg);
    end
    hold(1'b0, 40);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
